rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single write port of the 32x32 register file among NREQ writeback sources (ALU, LSU, MDU).
//   - Round-robin arbitration, valid/ready handshake per source.
//   - Registered write stage drives the RF write port.
//   - Pending-write scoreboard (busy_vec) that the issue stage uses for RAW/WAW stalls.
//   - Sits between the execute units and the register file in the multicycle/pipelined CPU.
// PARAMETERS
//   NREQ  3   number of writeback requesters (>=2)
//   AW    5   register address width
//   DW    32  register data width
// PORTS
//   clk        in   1        clock; all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   req_valid  in   NREQ     source i presents a write
//   req_addr   in   NREQ*AW  dest reg of source i; slice i = [i*AW +: AW]
//   req_data   in   NREQ*DW  write data of source i; slice i = [i*DW +: DW]
//   req_ready  out  NREQ     one-hot grant; handshake completes when valid&ready
//   wb_hold    in   1        1 = grant nothing this cycle
//   iss_valid  in   1        issue stage dispatches an instruction writing iss_rd
//   iss_rd     in   AW       dest reg of the issued instruction
//   flush      in   1        pipeline flush; clears the scoreboard
//   rf_we      out  1        RF write enable (registered)
//   rf_waddr   out  AW       RF write address (registered)
//   rf_wdata   out  DW       RF write data (registered)
//   busy_vec   out  2**AW    bit r = 1: write to reg r is pending; bit 0 is always 0
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous):
//     - rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, rr pointer=0.
//     - req_ready forced to 0 for as long as rst_n is low.
//     - A transfer cut by reset is lost; the source re-presents it after reset.
//   - Arbitration (combinational within the cycle):
//     - Search starts at ptr and runs ptr, ptr+1, ..., wrapping mod NREQ.
//     - The first i with req_valid[i]=1 gets req_ready[i]=1.
//     - At most one grant per cycle. No grant when wb_hold=1.
//     - req_ready may depend on req_valid.
//     - Sources hold valid/addr/data stable until granted; valid is never dropped before grant.
//   - Pointer update: after a grant to i, ptr <= (i+1) mod NREQ. No grant leaves ptr unchanged.
//   - Write stage, 1-cycle latency: a grant at posedge k produces, for the cycle after k:
//     - rf_we=1, rf_waddr=addr, rf_wdata=data.
//     - The RF captures the write on the following negedge.
//     - Without a grant, rf_we=0; rf_waddr and rf_wdata hold their last values.
//   - x0 writes: a request with addr=0 is granted (consumed) but rf_we stays 0.
//   - Scoreboard, updated at each posedge:
//     - Set: iss_valid & iss_rd!=0 sets busy[iss_rd].
//     - Clear: a grant clears busy[addr].
//     - Set and clear of the same reg in the same cycle: set wins (newer producer is pending).
//     - flush=1 clears all bits; an iss_valid in the same cycle is ignored.
//     - flush does not affect the arbiter or the write stage; granted writes still retire.
//     - Issuing to an already-busy rd is illegal (issue must stall); checked by assertion.
//   - Back-to-back: all sources valid continuously -> grants 0,1,2,0,1,2,..., with rf_we high every cycle.
// STRUCTURE
//   - Shared package rf_pkg:
//     - REG_AW=5, XLEN=32, NUM_WB_SRC=3.
//     - Source IDs SRC_ALU=0, SRC_LSU=1, SRC_MDU=2.
//   - Sub-module rr_arbiter (NREQ): req vector + hold -> one-hot grant, grant index, owns ptr register.
//   - Top level holds the grant mux, write-stage registers and the scoreboard.
// TESTING
//   - Reset: rst_n=0 mid-burst with all valids high -> req_ready=0, rf_we=0, busy_vec=0 immediately;
//     after release, first grant goes to source 0.
//   - Fairness: all 3 valid for 6 cycles -> grant order 0,1,2,0,1,2; rf_waddr follows one cycle later.
//   - Single write: source 1 requests x5=0xDEADBEEF at cycle k with ptr=2
//     -> ready[1] at k; at k+1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//   - x0 and hold:
//     - Source 0 writes x0 -> ready=1, rf_we=0.
//     - wb_hold=1 for 3 cycles -> no ready, ptr unchanged.
//   - Scoreboard:
//     - iss x7 -> busy[7]=1; LSU writeback x7 -> busy[7]=0 next cycle.
//     - Same-cycle iss x7 and grant x7 -> busy[7] stays 1.
//     - iss x0 -> busy_vec unchanged.
//   - Flush: busy = {x3,x9}, flush together with iss x4 -> busy_vec=0 next cycle; a pending grant still drives rf_we.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared constants for the register-file writeback path.
//   REG_AW     : register address width (32 architectural registers)
//   XLEN       : register data width
//   NUM_WB_SRC : number of writeback sources sharing the RF write port
//   wb_src_e   : source IDs, also the requester index at the arbiter
//   rr_next    : round-robin successor of an index, wrapping mod n
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int REG_AW     = 5;
    localparam int XLEN       = 32;
    localparam int NUM_WB_SRC = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } wb_src_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with an owned priority pointer. The search starts at
//   the pointer and wraps; the first asserted request wins. After a grant the
//   pointer moves just past the winner, so a continuously asserting source
//   yields to the others.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i       : request vector
//   hold_i      : 1 = grant nothing this cycle
//   gnt_o       : one-hot grant (forced to zero while in reset)
//   gnt_idx_o   : index of the winner (valid when gnt_vld_o)
//   gnt_vld_o   : a grant is issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            hold_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_vld_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx;
    logic          found;
    int            cand;

    always_comb begin
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

    // rst_n gates the grant combinationally so no handshake can complete
    // while the block is held in reset.
    assign gnt_vld_o = found && !hold_i && rst_n;
    assign gnt_idx_o = idx;
    assign gnt_o     = gnt_vld_o ? (NREQ'(1) << idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (gnt_vld_o) begin
            ptr_q <= IW'(rr_next(int'(idx), NREQ));
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single RF write port among NREQ writeback sources, registers
//   the winning write for one cycle, and keeps the pending-write scoreboard
//   the issue stage uses for RAW/WAW stalls.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/addr/data  : per-source write requests (slice i = source i)
//   req_ready            : one-hot grant; transfer on valid & ready
//   wb_hold              : suppress any grant this cycle
//   iss_valid, iss_rd    : issue-stage dispatch of an instruction writing rd
//   flush                : clear the scoreboard (arbiter/write stage unaffected)
//   rf_we/waddr/wdata    : registered RF write port
//   busy_vec             : bit r set while a write to r is pending; bit 0 = 0
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = NUM_WB_SRC,
    parameter int AW   = REG_AW,
    parameter int DW   = XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               wb_hold,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    input  logic               flush,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic [2**AW-1:0]   busy_vec
);

    localparam int IW   = $clog2(NREQ);
    localparam int NREG = 2**AW;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            rf_we_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [DW-1:0]   rf_wdata_q;
    logic [NREG-1:0] busy_q, busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_valid),
        .hold_i   (wb_hold),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx),
        .gnt_vld_o(gnt_vld)
    );

    assign req_ready = gnt;
    assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

    // A granted write retires its scoreboard bit; a same-cycle issue to the
    // same register is a newer producer, so the set is applied last.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (gnt_vld) busy_d[sel_addr] = 1'b0;
            if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            // x0 writes are consumed but never reach the RF.
            rf_we_q <= gnt_vld && (sel_addr != '0);
            if (gnt_vld) begin
                rf_waddr_q <= sel_addr;
                rf_wdata_q <= sel_data;
            end
            busy_q <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;

    // Issue must stall on a busy destination; flush cancels the issue.
    a_no_issue_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(iss_valid && !flush && iss_rd != '0 && busy_q[iss_rd]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        wb_hold = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wb_hold(wb_hold),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]           = v;
        req_addr[i*5 +: 5]     = a;
        req_data[i*32 +: 32]   = d;
    endtask

    // Checks the expected grant, queues the expected RF write, advances a cycle.
    task automatic grant_cycle(input string nm, input int g, input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        #1;
        chk(nm, 32'(req_ready), 32'(1) << g);
        if (a != 5'd0) begin
            w.a = a;
            w.d = d;
            exp_q.push_back(w);
        end
        step();
    endtask

    task automatic all_valid();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
    endtask

    // Monitor: every RF write the DUT presents must match the next queued one.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: got write x%0d=%h expected none", rf_waddr, rf_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                chk("wb_addr", 32'(rf_waddr), 32'(mon_w.a));
                chk("wb_data", rf_wdata, mon_w.d);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy_vec, 0);
        step(); step();
        rst_n = 1'b1;

        // Fairness: grants 0,1,2,0,1,2; write stage follows one cycle later
        all_valid();
        for (int k = 0; k < 6; k++) begin
            grant_cycle("fair_ready", k % 3, 5'(k % 3 + 1), 32'hA000_0000 + 32'(k % 3));
            chk("fair_we", 32'(rf_we), 1);
            chk("fair_waddr", 32'(rf_waddr), 32'(k % 3 + 1));
        end

        // Reset mid-burst, with a pending scoreboard bit and a write in flight
        iss_valid = 1'b1; iss_rd = 5'd12;
        grant_cycle("burst_ready", 0, 5'd1, 32'hA000_0000);
        iss_valid = 1'b0;
        chk("busy_x12", busy_vec, 32'(1) << 12);
        grant_cycle("burst_ready", 1, 5'd2, 32'hA000_0001);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 0);
        chk("midrst_we", 32'(rf_we), 0);
        chk("midrst_busy", busy_vec, 0);
        chk("midrst_waddr", 32'(rf_waddr), 0);
        chk("midrst_wdata", rf_wdata, 0);
        exp_q.delete();
        step(); step();
        #1;
        chk("inrst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        grant_cycle("postrst_ready", 0, 5'd1, 32'hA000_0000);
        chk("postrst_we", 32'(rf_we), 1);
        req_valid = '0;

        // Single write: bring ptr to 2, then source 1 writes x5
        set_req(1, 1'b1, 5'd6, 32'h0000_0011);
        grant_cycle("prep_ready", 1, 5'd6, 32'h0000_0011);
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        grant_cycle("single_ready", 1, 5'd5, 32'hDEAD_BEEF);
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("single_we", 32'(rf_we), 1);
        chk("single_waddr", 32'(rf_waddr), 5);
        chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
        step();
        chk("idle_we", 32'(rf_we), 0);
        chk("idle_waddr_hold", 32'(rf_waddr), 5);
        chk("idle_wdata_hold", rf_wdata, 32'hDEAD_BEEF);

        // x0 write: consumed, no RF write (ptr 2 -> 1)
        set_req(0, 1'b1, 5'd0, 32'h0000_1234);
        grant_cycle("x0_ready", 0, 5'd0, 32'h0000_1234);
        set_req(0, 1'b0, 5'd0, 32'h0);
        chk("x0_we", 32'(rf_we), 0);

        // Hold for 3 cycles: no grant, ptr stays at 1
        wb_hold = 1'b1;
        all_valid();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", 32'(req_ready), 0);
            step();
            chk("hold_we", 32'(rf_we), 0);
        end
        wb_hold = 1'b0;
        grant_cycle("hold_release", 1, 5'd2, 32'hA000_0001);
        req_valid = '0;

        // Scoreboard set / clear (ptr = 2)
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        chk("iss_x7", busy_vec, 32'(1) << 7);
        set_req(1, 1'b1, 5'd7, 32'h0000_0077);
        grant_cycle("lsu_ready", 1, 5'd7, 32'h0000_0077);
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("lsu_clr_x7", busy_vec, 0);

        // Same-cycle issue x7 and grant x7: set wins
        set_req(2, 1'b1, 5'd7, 32'h0000_0088);
        iss_valid = 1'b1; iss_rd = 5'd7;
        grant_cycle("same_ready", 2, 5'd7, 32'h0000_0088);
        iss_valid = 1'b0;
        set_req(2, 1'b0, 5'd0, 32'h0);
        chk("same_busy", busy_vec, 32'(1) << 7);

        // Issue to x0 leaves the scoreboard alone
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0;
        chk("iss_x0", busy_vec, 32'(1) << 7);

        // Retire x7 (ptr 0 -> 1), then busy = {x3, x9}
        set_req(0, 1'b1, 5'd7, 32'h0000_0099);
        grant_cycle("clr7_ready", 0, 5'd7, 32'h0000_0099);
        set_req(0, 1'b0, 5'd0, 32'h0);
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        chk("busy_3_9", busy_vec, 32'h0000_0208);

        // Flush with iss x4 and a concurrent grant: scoreboard clears, write retires
        set_req(2, 1'b1, 5'd10, 32'h0000_00AA);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        grant_cycle("flush_ready", 2, 5'd10, 32'h0000_00AA);
        flush = 1'b0; iss_valid = 1'b0;
        set_req(2, 1'b0, 5'd0, 32'h0);
        chk("flush_busy", busy_vec, 0);
        chk("flush_we", 32'(rf_we), 1);
        chk("flush_waddr", 32'(rf_waddr), 10);

        step(); step();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
